// File: rtl/id_ex_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_reg_if
// Bundle of signals between the decode stage / hazard unit and the ID/EX
// pipeline register, plus the registered EX-stage copies it produces.
//
// Parameters
//   XLEN   width of PC, operand and immediate fields
//   CNT_W  width of the bubble counter
//
// Signal groups
//   stall, flush                      hazard-unit requests
//   id_*                              decode-stage instruction fields
//   ex_*                              registered EX-stage copies
//   bubble_cnt                        number of bubbles presented to EX
//
// Modports
//   master  driven by decode / hazard logic, observes EX copies
//   slave   the ID/EX register itself
// ---------------------------------------------------------------------------
interface id_ex_reg_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
);

   // Hazard-unit requests
   logic             stall;
   logic             flush;

   // Decode-stage fields
   logic             id_valid;
   logic [XLEN-1:0]  id_pc;
   logic [XLEN-1:0]  id_rs1_data;
   logic [XLEN-1:0]  id_rs2_data;
   logic [XLEN-1:0]  id_imm;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       id_rd;
   logic [1:0]       id_alu_op;
   logic [3:0]       id_alu_funct;
   logic             id_alu_src;
   logic             id_reg_write;
   logic             id_mem_read;
   logic             id_mem_write;
   logic             id_mem_to_reg;
   logic             id_branch;

   // Registered EX-stage copies
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_rs1_data;
   logic [XLEN-1:0]  ex_rs2_data;
   logic [XLEN-1:0]  ex_imm;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic [1:0]       ex_alu_op;
   logic [3:0]       ex_alu_funct;
   logic             ex_alu_src;
   logic             ex_reg_write;
   logic             ex_mem_read;
   logic             ex_mem_write;
   logic             ex_mem_to_reg;
   logic             ex_branch;

   logic [CNT_W-1:0] bubble_cnt;

   modport master (
      output stall, flush,
      output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
      output id_rs1, id_rs2, id_rd, id_alu_op, id_alu_funct,
      output id_alu_src, id_reg_write, id_mem_read, id_mem_write,
      output id_mem_to_reg, id_branch,
      input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
      input  ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_funct,
      input  ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
      input  ex_mem_to_reg, ex_branch,
      input  bubble_cnt
   );

   modport slave (
      input  stall, flush,
      input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
      input  id_rs1, id_rs2, id_rd, id_alu_op, id_alu_funct,
      input  id_alu_src, id_reg_write, id_mem_read, id_mem_write,
      input  id_mem_to_reg, id_branch,
      output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
      output ex_rs1, ex_rs2, ex_rd, ex_alu_op, ex_alu_funct,
      output ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write,
      output ex_mem_to_reg, ex_branch,
      output bubble_cnt
   );

endinterface

// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with stall, flush and bubble accounting.
//
// Parameters
//   XLEN   width of PC, operand and immediate fields
//   CNT_W  width of the saturating bubble counter
//
// Ports
//   clk    pipeline clock, all updates on the rising edge
//   rst    asynchronous active-high reset
//   bus    id_ex_reg_if.slave: stall/flush, id_* inputs, ex_* and
//          bubble_cnt outputs (all outputs come straight from flops)
//
// Update priority per edge: rst > flush > stall > load.
// ---------------------------------------------------------------------------
module id_ex_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   id_ex_reg_if.slave  bus
);

   // Every bubble value is zero, so an all-zero stage is the NOP.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [1:0]      alu_op;
      logic [3:0]      alu_funct;
      logic            alu_src;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            branch;
   } stage_t;

   stage_t           stage_q;
   stage_t           stage_d;
   stage_t           load_d;
   logic [3:0]       norm_funct;
   logic             cnt_inc;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Funct normalisation: for an immediate-form funct-decoded op, bit 30 of
   // the instruction is part of the immediate, so it must not turn ADDI etc.
   // into SUB. SRAI (funct3 = 101) genuinely uses bit 30 and keeps it.
   always_comb begin
      norm_funct = bus.id_alu_funct;
      if (bus.id_alu_op[1] && bus.id_alu_src && (bus.id_alu_funct[2:0] != 3'b101)) begin
         norm_funct[3] = 1'b0;
      end
   end

   // Value the stage takes on a normal load. Data and index fields always
   // follow decode; control fields (including rd) only when id_valid is set,
   // so an invalid slot reaches EX as a harmless bubble.
   always_comb begin
      load_d          = '0;
      load_d.pc       = bus.id_pc;
      load_d.rs1_data = bus.id_rs1_data;
      load_d.rs2_data = bus.id_rs2_data;
      load_d.imm      = bus.id_imm;
      load_d.rs1      = bus.id_rs1;
      load_d.rs2      = bus.id_rs2;
      if (bus.id_valid) begin
         load_d.valid      = 1'b1;
         load_d.rd         = bus.id_rd;
         load_d.alu_op     = bus.id_alu_op;
         load_d.alu_funct  = norm_funct;
         load_d.alu_src    = bus.id_alu_src;
         load_d.reg_write  = bus.id_reg_write;
         load_d.mem_read   = bus.id_mem_read;
         load_d.mem_write  = bus.id_mem_write;
         load_d.mem_to_reg = bus.id_mem_to_reg;
         load_d.branch     = bus.id_branch;
      end
   end

   // Next-state selection. A bubble is counted when flush inserts one or when
   // an invalid slot is loaded; a held stall keeps the old contents and does
   // not count again.
   always_comb begin
      stage_d = stage_q;
      cnt_inc = 1'b0;
      if (bus.flush) begin
         stage_d = '0;
         cnt_inc = 1'b1;
      end else if (!bus.stall) begin
         stage_d = load_d;
         cnt_inc = !bus.id_valid;
      end
   end

   // Saturating bubble counter: it sticks at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers. Reset forces the bubble immediately, without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.ex_valid      = stage_q.valid;
   assign bus.ex_pc         = stage_q.pc;
   assign bus.ex_rs1_data   = stage_q.rs1_data;
   assign bus.ex_rs2_data   = stage_q.rs2_data;
   assign bus.ex_imm        = stage_q.imm;
   assign bus.ex_rs1        = stage_q.rs1;
   assign bus.ex_rs2        = stage_q.rs2;
   assign bus.ex_rd         = stage_q.rd;
   assign bus.ex_alu_op     = stage_q.alu_op;
   assign bus.ex_alu_funct  = stage_q.alu_funct;
   assign bus.ex_alu_src    = stage_q.alu_src;
   assign bus.ex_reg_write  = stage_q.reg_write;
   assign bus.ex_mem_read   = stage_q.mem_read;
   assign bus.ex_mem_write  = stage_q.mem_write;
   assign bus.ex_mem_to_reg = stage_q.mem_to_reg;
   assign bus.ex_branch     = stage_q.branch;
   assign bus.bubble_cnt    = cnt_q;

endmodule
